// File: rtl/scan_mem_loader.sv
// Serial scan receiver: shifts address/data words in, runs single-word
// CMEM/DMEM accesses, shifts readback out and gates execution start.
module scan_mem_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_in,
    input  logic              scan_en,
    input  logic              scan_data_or_addr,
    input  logic              read_write,
    input  logic              scan_update,
    input  logic              scan_start_exec,
    input  logic              exec_end,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cmem_ce,
    output logic              dmem_ce,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              scan_out,
    output logic              busy,
    output logic              exec_start,
    output logic              exec_done,
    output logic              load_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR      = 2'd1;
    localparam logic [1:0] S_RD_REQ  = 2'd2;
    localparam logic [1:0] S_RD_WAIT = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic              sel_cmem;
    logic              start_q;
    logic              end_q;
    logic              exec_pend;

    logic idle;
    logic commit;
    logic shift;
    logic access;
    logic start_rise;
    logic end_rise;
    logic fire;

    always_comb begin
        idle       = (state == S_IDLE);
        commit     = scan_update && idle && !scan_start_exec;
        shift      = scan_en && idle && !scan_update;
        access     = (state == S_WR) || (state == S_RD_REQ);
        start_rise = scan_start_exec && !start_q;
        end_rise   = exec_end && !end_q;
        // a rise seen while busy stays pending until the FSM is idle again
        fire       = scan_start_exec && idle && (start_rise || exec_pend);
    end

    assign cmem_ce  = access && sel_cmem;
    assign dmem_ce  = access && !sel_cmem;
    assign mem_we   = (state == S_WR);
    assign busy     = !idle;
    assign scan_out = data_sr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_sr   <= '0;
            data_sr   <= '0;
            sel_cmem  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (commit) begin
                        mem_addr  <= addr_sr[ADDR_W-2:0];
                        mem_wdata <= data_sr;
                        sel_cmem  <= addr_sr[ADDR_W-1];
                        state     <= read_write ? S_WR : S_RD_REQ;
                    end else if (shift) begin
                        if (scan_data_or_addr)
                            data_sr <= {scan_in, data_sr[DATA_W-1:1]};
                        else
                            addr_sr <= {scan_in, addr_sr[ADDR_W-1:1]};
                    end
                end
                S_WR:      state <= S_IDLE;
                S_RD_REQ:  state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    data_sr <= mem_rdata;
                    state   <= S_IDLE;
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            exec_pend  <= 1'b0;
            exec_start <= 1'b0;
            exec_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            start_q    <= scan_start_exec;
            end_q      <= exec_end;
            exec_pend  <= scan_start_exec && !fire
                          && (exec_pend || start_rise);
            exec_start <= fire;
            if (scan_update && !commit)
                load_err <= 1'b1;
            if (fire)
                exec_done <= 1'b0;
            else if (end_rise && scan_start_exec)
                exec_done <= 1'b1;
        end
    end

endmodule
